// File: rtl/player_shot_controller.sv
// player_shot_controller
//
// Owns the player's single laser shot. A fire-button press launches the shot
// from the cannon muzzle. The shot then climbs the playfield in fixed steps on
// a periodic move tick. It retires on a hit reported by the alien controller
// or when it passes the top border, and a cooldown must expire before the
// cannon re-arms. The shot is also rendered for the VGA mixer, with a 2-cycle
// pixel latency that lines up with the alien sprite pipeline.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   pause        freezes state, counters, position and hit count (render runs on)
//   fire         synchronized fire-button level
//   player_x     cannon muzzle x (shot's left column)
//   player_y     cannon top row
//   shot_hit     one-cycle hit pulse from the alien controller
//   pixel_x/y    current VGA pixel
//   shot_active  shot in flight
//   shot_x/y     shot top-left corner, used as the collision point
//   shot_on      current pixel (2 cycles ago) belongs to the shot
//   shot_rgb     shot colour, or 0 when off
//   hit_count    saturating count of confirmed hits

module player_shot_controller #(
    parameter int unsigned SHOT_WIDTH      = 2,
    parameter int unsigned SHOT_HEIGHT     = 8,
    parameter int unsigned SHOT_VELOCITY   = 4,
    parameter int unsigned MOVE_INTERVAL   = 200000,
    parameter int unsigned COOLDOWN_CYCLES = 5000000,
    parameter int unsigned Y_TOP           = 40,
    parameter logic [11:0] SHOT_RGB        = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pause,
    input  logic        fire,
    input  logic [10:0] player_x,
    input  logic [10:0] player_y,
    input  logic        shot_hit,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    output logic        shot_active,
    output logic [10:0] shot_x,
    output logic [10:0] shot_y,
    output logic        shot_on,
    output logic [11:0] shot_rgb,
    output logic [7:0]  hit_count
);

    localparam int unsigned MoveCntW = (MOVE_INTERVAL > 0) ? $clog2(MOVE_INTERVAL + 1) : 1;
    localparam int unsigned CoolLast = (COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0;
    localparam int unsigned CoolCntW = (CoolLast > 0) ? $clog2(CoolLast + 1) : 1;

    localparam logic [MoveCntW-1:0] MoveLast   = MoveCntW'(MOVE_INTERVAL);
    localparam logic [CoolCntW-1:0] CoolLastW  = CoolCntW'(CoolLast);
    // Thresholds are 12 bits wide so the sums can never wrap.
    localparam logic [11:0]         LaunchMinY = 12'(Y_TOP + SHOT_HEIGHT);
    localparam logic [11:0]         MissY      = 12'(Y_TOP + SHOT_VELOCITY);
    localparam logic [10:0]         HeightW    = 11'(SHOT_HEIGHT);
    localparam logic [10:0]         VelocityW  = 11'(SHOT_VELOCITY);

    typedef enum logic [1:0] {
        StIdle,
        StFlying,
        StCooldown
    } state_e;

    state_e                state_q, state_d;
    logic [MoveCntW-1:0]   move_cnt_q, move_cnt_d;
    logic [CoolCntW-1:0]   cool_cnt_q, cool_cnt_d;
    logic [10:0]           shot_x_q, shot_x_d;
    logic [10:0]           shot_y_q, shot_y_d;
    logic [7:0]            hit_count_q, hit_count_d;
    logic                  shot_active_q, shot_active_d;
    logic                  fire_q, fire_d;

    // Render pipeline
    logic                  render_hit_q, render_hit_d;
    logic                  shot_on_q, shot_on_d;
    logic [11:0]           shot_rgb_q, shot_rgb_d;

    logic                  fire_rise;
    logic                  move_tick;
    logic [11:0]           x_end;
    logic [11:0]           y_end;

    assign fire_rise = fire & ~fire_q;
    assign move_tick = (move_cnt_q == MoveLast);

    // ------------------------------------------------------------------
    // Shot FSM: next state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        move_cnt_d  = move_cnt_q;
        cool_cnt_d  = cool_cnt_q;
        shot_x_d    = shot_x_q;
        shot_y_d    = shot_y_q;
        hit_count_d = hit_count_q;
        // The edge register runs even while paused, so a press made during
        // pause is consumed rather than replayed afterwards.
        fire_d      = fire;

        if (!pause) begin
            case (state_q)
                StIdle: begin
                    if (fire_rise && ({1'b0, player_y} >= LaunchMinY)) begin
                        state_d    = StFlying;
                        shot_x_d   = player_x;
                        shot_y_d   = player_y - HeightW;
                        move_cnt_d = '0;
                    end
                end

                StFlying: begin
                    if (shot_hit) begin
                        // A hit outranks a coincident move tick.
                        state_d    = StCooldown;
                        cool_cnt_d = '0;
                        if (hit_count_q != 8'hFF) begin
                            hit_count_d = hit_count_q + 8'd1;
                        end
                    end else if (move_tick) begin
                        move_cnt_d = '0;
                        if ({1'b0, shot_y_q} < MissY) begin
                            state_d    = StCooldown;
                            cool_cnt_d = '0;
                        end else begin
                            shot_y_d = shot_y_q - VelocityW;
                        end
                    end else begin
                        move_cnt_d = move_cnt_q + 1'b1;
                    end
                end

                StCooldown: begin
                    if (cool_cnt_q >= CoolLastW) begin
                        state_d = StIdle;
                    end else begin
                        cool_cnt_d = cool_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        shot_active_d = (state_d == StFlying);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            move_cnt_q    <= '0;
            cool_cnt_q    <= '0;
            shot_x_q      <= '0;
            shot_y_q      <= '0;
            hit_count_q   <= '0;
            shot_active_q <= 1'b0;
            // Held high so a button pressed across reset does not fire.
            fire_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            move_cnt_q    <= move_cnt_d;
            cool_cnt_q    <= cool_cnt_d;
            shot_x_q      <= shot_x_d;
            shot_y_q      <= shot_y_d;
            hit_count_q   <= hit_count_d;
            shot_active_q <= shot_active_d;
            fire_q        <= fire_d;
        end
    end

    // ------------------------------------------------------------------
    // Render: stage 1 box test, stage 2 colour
    // ------------------------------------------------------------------
    assign x_end = {1'b0, shot_x_q} + 12'(SHOT_WIDTH);
    assign y_end = {1'b0, shot_y_q} + 12'(SHOT_HEIGHT);

    always_comb begin
        render_hit_d = shot_active_q
                    && (pixel_x >= shot_x_q) && ({1'b0, pixel_x} < x_end)
                    && (pixel_y >= shot_y_q) && ({1'b0, pixel_y} < y_end);
        shot_on_d    = render_hit_q;
        shot_rgb_d   = render_hit_q ? SHOT_RGB : 12'h000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            render_hit_q <= 1'b0;
            shot_on_q    <= 1'b0;
            shot_rgb_q   <= '0;
        end else begin
            render_hit_q <= render_hit_d;
            shot_on_q    <= shot_on_d;
            shot_rgb_q   <= shot_rgb_d;
        end
    end

    assign shot_active = shot_active_q;
    assign shot_x      = shot_x_q;
    assign shot_y      = shot_y_q;
    assign hit_count   = hit_count_q;
    assign shot_on     = shot_on_q;
    assign shot_rgb    = shot_rgb_q;

endmodule

// File: tb/tb_player_shot_controller.sv
module tb_player_shot_controller;

    localparam int MI    = 3;
    localparam int CD    = 5;
    localparam int YTOP  = 40;
    localparam int VEL   = 4;
    localparam int HGT   = 8;
    localparam int WID   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pause = 1'b0;
    logic        fire = 1'b1;
    logic [10:0] player_x = 11'd300;
    logic [10:0] player_y = 11'd440;
    logic        shot_hit = 1'b0;
    logic [10:0] pixel_x = 11'd0;
    logic [10:0] pixel_y = 11'd0;
    logic        shot_active;
    logic [10:0] shot_x;
    logic [10:0] shot_y;
    logic        shot_on;
    logic [11:0] shot_rgb;
    logic [7:0]  hit_count;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    player_shot_controller #(
        .SHOT_WIDTH      (WID),
        .SHOT_HEIGHT     (HGT),
        .SHOT_VELOCITY   (VEL),
        .MOVE_INTERVAL   (MI),
        .COOLDOWN_CYCLES (CD),
        .Y_TOP           (YTOP),
        .SHOT_RGB        (12'hFFF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pause       (pause),
        .fire        (fire),
        .player_x    (player_x),
        .player_y    (player_y),
        .shot_hit    (shot_hit),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .shot_active (shot_active),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .shot_on     (shot_on),
        .shot_rgb    (shot_rgb),
        .hit_count   (hit_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: shot lifetime in terms of "cycles until next move"
    // and "cooldown cycles remaining", plus a 2-deep render delay line.
    // ------------------------------------------------------------------
    bit m_fly = 0;
    int m_x = 0, m_y = 0, m_hits = 0;
    int m_since = 0;     // cycles since launch or last move
    int m_cool_left = 0; // >0 while cooling down
    bit m_prev_fire = 1;
    bit m_rise;
    bit m_r1 = 0, m_r2 = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_fly = 0; m_x = 0; m_y = 0; m_hits = 0; m_since = 0;
            m_cool_left = 0; m_prev_fire = 1; m_r1 = 0; m_r2 = 0;
        end else begin
            m_rise = fire && !m_prev_fire;
            m_prev_fire = fire;
            m_r2 = m_r1;
            m_r1 = m_fly && (int'(pixel_x) >= m_x) && (int'(pixel_x) < m_x + WID)
                         && (int'(pixel_y) >= m_y) && (int'(pixel_y) < m_y + HGT);
            if (!pause) begin
                if (m_fly) begin
                    if (shot_hit) begin
                        m_fly = 0;
                        m_cool_left = CD;
                        if (m_hits < 255) m_hits++;
                    end else if (m_since == MI) begin
                        m_since = 0;
                        if (m_y < YTOP + VEL) begin
                            m_fly = 0;
                            m_cool_left = CD;
                        end else begin
                            m_y = m_y - VEL;
                        end
                    end else begin
                        m_since++;
                    end
                end else if (m_cool_left > 0) begin
                    m_cool_left--;
                end else if (m_rise && int'(player_y) >= YTOP + HGT) begin
                    m_fly = 1;
                    m_x = int'(player_x);
                    m_y = int'(player_y) - HGT;
                    m_since = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking && !reset) begin
            chk("m_active", {31'd0, shot_active}, {31'd0, m_fly});
            chk("m_shot_x", {21'd0, shot_x}, m_x);
            chk("m_shot_y", {21'd0, shot_y}, m_y);
            chk("m_hit_count", {24'd0, hit_count}, m_hits);
            chk("m_shot_on", {31'd0, shot_on}, {31'd0, m_r2});
            chk("m_shot_rgb", {20'd0, shot_rgb}, m_r2 ? 32'hFFF : 32'h0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int launches;
    bit prev_act;

    initial begin
        // Reset values, fire held through reset
        cyc(2);
        chk("rst_active", {31'd0, shot_active}, 0);
        chk("rst_hits", {24'd0, hit_count}, 0);
        chk("rst_shot_on", {31'd0, shot_on}, 0);
        chk("rst_rgb", {20'd0, shot_rgb}, 0);
        reset = 1'b0;
        checking = 1'b1;
        cyc(10);
        chk("held_fire_no_launch", {31'd0, shot_active}, 0);

        // Launch at (300,440)
        fire = 1'b0;
        cyc(1);
        fire = 1'b1;
        cyc(1);
        chk("launch_active", {31'd0, shot_active}, 1);
        chk("launch_x", {21'd0, shot_x}, 300);
        chk("launch_y", {21'd0, shot_y}, 432);
        pixel_x = 11'd301; pixel_y = 11'd435;
        cyc(1);
        chk("render_lat1", {31'd0, shot_on}, 0);
        cyc(1);
        chk("render_on", {31'd0, shot_on}, 1);
        chk("render_rgb", {20'd0, shot_rgb}, 32'hFFF);
        pixel_x = 11'd302;
        cyc(2);
        chk("render_x_edge", {31'd0, shot_on}, 0);
        chk("move1_y", {21'd0, shot_y}, 428);
        pixel_x = 11'd300; pixel_y = 11'd440;
        pause = 1'b1;
        cyc(2);
        chk("render_y_edge", {31'd0, shot_on}, 0);
        cyc(48);
        chk("pause_y", {21'd0, shot_y}, 428);
        pause = 1'b0;
        cyc(3);
        chk("pause_cnt_frozen", {21'd0, shot_y}, 428);
        cyc(1);
        chk("move2_y", {21'd0, shot_y}, 424);

        // Hit, ignored rise during cooldown, re-arm
        shot_hit = 1'b1;
        cyc(1);
        shot_hit = 1'b0;
        chk("hit_retire", {31'd0, shot_active}, 0);
        chk("hit_count1", {24'd0, hit_count}, 1);
        fire = 1'b0;
        cyc(1);
        fire = 1'b1;
        cyc(1);
        chk("cool_rise_ignored", {31'd0, shot_active}, 0);
        fire = 1'b0;
        cyc(3);
        fire = 1'b1;
        cyc(1);
        chk("rearm_launch", {31'd0, shot_active}, 1);

        // Hit coincident with a move tick
        cyc(3);
        shot_hit = 1'b1;
        cyc(1);
        shot_hit = 1'b0;
        chk("hit_tick_y", {21'd0, shot_y}, 432);
        chk("hit_tick_count", {24'd0, hit_count}, 2);

        // Miss off the top border
        cyc(5);
        player_y = 11'd60;
        fire = 1'b0;
        cyc(1);
        fire = 1'b1;
        cyc(1);
        chk("miss_y0", {21'd0, shot_y}, 52);
        cyc(4); chk("miss_y1", {21'd0, shot_y}, 48);
        cyc(4); chk("miss_y2", {21'd0, shot_y}, 44);
        cyc(4); chk("miss_y3", {21'd0, shot_y}, 40);
        cyc(4);
        chk("miss_retire", {31'd0, shot_active}, 0);
        chk("miss_hits", {24'd0, hit_count}, 2);
        cyc(3);
        fire = 1'b0;
        cyc(1);
        fire = 1'b1;
        cyc(1);
        chk("cool_last_cycle", {31'd0, shot_active}, 0);
        fire = 1'b0;
        cyc(1);
        fire = 1'b1;
        cyc(1);
        chk("idle_after_cool", {31'd0, shot_active}, 1);

        // Saturating hit counter
        for (int i = 0; i < 256; i++) begin
            shot_hit = 1'b1;
            cyc(1);
            shot_hit = 1'b0;
            cyc(5);
            fire = 1'b0;
            cyc(1);
            fire = 1'b1;
            cyc(1);
        end
        chk("hits_sat", {24'd0, hit_count}, 255);
        shot_hit = 1'b1;
        cyc(1);
        shot_hit = 1'b0;
        chk("hits_sat_hold", {24'd0, hit_count}, 255);
        cyc(5);

        // Rise during pause in IDLE is consumed
        pause = 1'b1;
        fire = 1'b0;
        cyc(1);
        fire = 1'b1;
        cyc(2);
        pause = 1'b0;
        cyc(3);
        chk("pause_rise_dropped", {31'd0, shot_active}, 0);

        // Launch height boundary
        fire = 1'b0;
        player_y = 11'd47;
        cyc(1);
        fire = 1'b1;
        cyc(2);
        chk("low_y_rejected", {31'd0, shot_active}, 0);
        fire = 1'b0;
        player_y = 11'd48;
        cyc(1);
        fire = 1'b1;
        cyc(1);
        chk("min_y_launch", {31'd0, shot_active}, 1);
        chk("min_y_pos", {21'd0, shot_y}, 40);
        cyc(4);
        chk("min_y_miss", {31'd0, shot_active}, 0);
        cyc(5);

        // Holding fire yields one shot
        player_y = 11'd440;
        fire = 1'b0;
        cyc(1);
        fire = 1'b1;
        launches = 0;
        prev_act = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            if (shot_active && !prev_act) launches++;
            prev_act = shot_active;
        end
        chk("hold_one_shot", launches, 1);

        // Reset mid-flight
        fire = 1'b0;
        cyc(1);
        fire = 1'b1;
        cyc(1);
        chk("pre_reset_active", {31'd0, shot_active}, 1);
        cyc(2);
        reset = 1'b1;
        #1;
        chk("mid_rst_active", {31'd0, shot_active}, 0);
        chk("mid_rst_y", {21'd0, shot_y}, 0);
        chk("mid_rst_hits", {24'd0, hit_count}, 0);
        cyc(2);
        reset = 1'b0;
        cyc(5);
        chk("post_rst_no_launch", {31'd0, shot_active}, 0);

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
